// File: rtl/if_fetch_ctrl.sv
// Fetch-stage controller: paces the PC register against a req/gnt/rvalid
// instruction memory with one fetch in flight at a time. Redirects from
// execute are buffered while a fetch is outstanding. A stalled fetch ends in
// HALT with a sticky error.
module if_fetch_ctrl #(
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    localparam int unsigned XLEN          = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] PCF,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic            StallD,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            StallF,
    output logic            PCSrcF,
    output logic [XLEN-1:0] PCTargetF,
    output logic [XLEN-1:0] InstrF,
    output logic            InstrValidF,
    output logic            fetch_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        REDIR = 3'd4,
        HALT  = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic              redir_pend_q, redir_pend_d;
    logic [XLEN-1:0]   redir_tgt_q, redir_tgt_d;
    logic [XLEN-1:0]   instr_buf_q, instr_buf_d;
    logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              fetch_err_q, fetch_err_d;
    logic              tmo_last;

    // The memory always sees the live PC; the PC register is held while a
    // request is waiting for its grant, so the address cannot move under it.
    assign imem_addr = PCF;
    assign fetch_err = fetch_err_q;

    // One more idle cycle in REQ/WAIT would reach the timeout limit.
    assign tmo_last = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Next-state, redirect buffering, timeout tracking and PC-side controls.
    always_comb begin
        state_d      = state_q;
        redir_pend_d = redir_pend_q;
        redir_tgt_d  = redir_tgt_q;
        instr_buf_d  = instr_buf_q;
        tmo_cnt_d    = '0;
        fetch_err_d  = fetch_err_q;
        imem_req     = 1'b0;
        StallF       = 1'b1;
        PCSrcF       = 1'b0;
        PCTargetF    = redir_tgt_q;
        InstrValidF  = 1'b0;
        InstrF       = NOP_INSTR;

        // Redirects seen while a fetch is being set up or is in flight are
        // parked here; the newest one wins.
        if (PCSrcE && (state_q inside {IDLE, REQ, WAIT})) begin
            redir_pend_d = 1'b1;
            redir_tgt_d  = PCTargetE;
        end

        unique case (state_q)
            IDLE: begin
                state_d = REQ;
            end

            REQ: begin
                imem_req = 1'b1;
                if (imem_gnt) begin
                    state_d = WAIT;
                end else if (tmo_last) begin
                    state_d     = HALT;
                    fetch_err_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
            end

            WAIT: begin
                if (imem_rvalid) begin
                    // Data fetched down a path that execute has abandoned is dropped.
                    if (redir_pend_q || PCSrcE) begin
                        state_d = REDIR;
                    end else begin
                        instr_buf_d = imem_rdata;
                        state_d     = HOLD;
                    end
                end else if (tmo_last) begin
                    state_d     = HALT;
                    fetch_err_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
            end

            HOLD: begin
                InstrValidF = !PCSrcE && !redir_pend_q;
                if (InstrValidF) begin
                    InstrF = instr_buf_q;
                end
                if (PCSrcE) begin
                    // A live redirect overrides decode back-pressure.
                    StallF       = 1'b0;
                    PCSrcF       = 1'b1;
                    PCTargetF    = PCTargetE;
                    redir_pend_d = 1'b0;
                    instr_buf_d  = NOP_INSTR;
                    state_d      = REQ;
                end else if (redir_pend_q) begin
                    StallF       = 1'b0;
                    PCSrcF       = 1'b1;
                    PCTargetF    = redir_tgt_q;
                    redir_pend_d = 1'b0;
                    instr_buf_d  = NOP_INSTR;
                    state_d      = REQ;
                end else if (!StallD) begin
                    // Decode takes the instruction at this edge; PC moves to PC+4.
                    StallF      = 1'b0;
                    instr_buf_d = NOP_INSTR;
                    state_d     = REQ;
                end
            end

            REDIR: begin
                StallF       = 1'b0;
                PCSrcF       = 1'b1;
                PCTargetF    = PCSrcE ? PCTargetE : redir_tgt_q;
                redir_pend_d = 1'b0;
                state_d      = REQ;
            end

            HALT: begin
                state_d = HALT;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset quiets the memory side and freezes the PC in the same cycle.
        if (rst) begin
            imem_req    = 1'b0;
            StallF      = 1'b1;
            PCSrcF      = 1'b0;
            InstrValidF = 1'b0;
            InstrF      = NOP_INSTR;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            redir_pend_q <= 1'b0;
            redir_tgt_q  <= '0;
            instr_buf_q  <= NOP_INSTR;
            tmo_cnt_q    <= '0;
            fetch_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            redir_pend_q <= redir_pend_d;
            redir_tgt_q  <= redir_tgt_d;
            instr_buf_q  <= instr_buf_d;
            tmo_cnt_q    <= tmo_cnt_d;
            fetch_err_q  <= fetch_err_d;
        end
    end

    // Structural invariants of the handshake and PC controls.
    a_req_holds_pc: assert property (@(posedge clk) disable iff (rst)
        imem_req |-> StallF);
    a_redirect_moves_pc: assert property (@(posedge clk) disable iff (rst)
        PCSrcF |-> !StallF);
    a_valid_only_in_hold: assert property (@(posedge clk) disable iff (rst)
        InstrValidF |-> (state_q == HOLD));
    a_err_means_halt: assert property (@(posedge clk) disable iff (rst)
        fetch_err_q |-> (state_q == HALT));
    a_addr_stable: assert property (@(posedge clk) disable iff (rst)
        (imem_req && !imem_gnt) |=> (imem_addr == $past(imem_addr)));

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: a directed cycle table, a hand-written timeout
// sequence, then randomized traffic against a rule-based reference model.
// The bench owns the PC register and updates it from the expected controls.
module tb_if_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCF;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        StallD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        StallF;
    logic        PCSrcF;
    logic [31:0] PCTargetF;
    logic [31:0] InstrF;
    logic        InstrValidF;
    logic        fetch_err;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] pc       = 32'h0;

    always #5 clk = ~clk;

    if_fetch_ctrl #(
        .NOP_INSTR      (NOP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .PCF         (PCF),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .StallD      (StallD),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .StallF      (StallF),
        .PCSrcF      (PCSrcF),
        .PCTargetF   (PCTargetF),
        .InstrF      (InstrF),
        .InstrValidF (InstrValidF),
        .fetch_err   (fetch_err)
    );

    typedef struct packed {
        logic        rst;
        logic        se;
        logic [31:0] te;
        logic        sd;
        logic        g;
        logic        rv;
        logic [31:0] rd;
        logic [31:0] e_addr;
        logic        e_req;
        logic        e_stall;
        logic        e_src;
        logic [31:0] e_tgt;
        logic        e_valid;
        logic [31:0] e_instr;
        logic        e_err;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic r, input logic se, input logic [31:0] te,
                                input logic sd, input logic g, input logic rv,
                                input logic [31:0] rd, input logic [31:0] ea,
                                input logic eq, input logic es, input logic ec,
                                input logic [31:0] et, input logic ev,
                                input logic [31:0] ei, input logic ee);
        vec_t v;
        v.rst = r;  v.se = se; v.te = te; v.sd = sd; v.g = g; v.rv = rv; v.rd = rd;
        v.e_addr = ea; v.e_req = eq; v.e_stall = es; v.e_src = ec; v.e_tgt = et;
        v.e_valid = ev; v.e_instr = ei; v.e_err = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and let outputs settle.
    task automatic drive(input logic r, input logic se, input logic [31:0] te,
                         input logic sd, input logic g, input logic rv,
                         input logic [31:0] rd);
        @(negedge clk);
        rst = r; PCSrcE = se; PCTargetE = te; StallD = sd;
        imem_gnt = g; imem_rvalid = rv; imem_rdata = rd; PCF = pc;
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [31:0] ea, input logic eq,
                              input logic es, input logic ec, input logic [31:0] et,
                              input logic ev, input logic [31:0] ei, input logic ee);
        check({tag, ".req"},   32'(imem_req),    32'(eq));
        check({tag, ".addr"},  imem_addr,        ea);
        check({tag, ".stall"}, 32'(StallF),      32'(es));
        check({tag, ".src"},   32'(PCSrcF),      32'(ec));
        if (ec) check({tag, ".tgt"}, PCTargetF, et);
        check({tag, ".valid"}, 32'(InstrValidF), 32'(ev));
        check({tag, ".instr"}, InstrF,           ei);
        check({tag, ".err"},   32'(fetch_err),   32'(ee));
        // PC register behaviour at the coming edge, from the expected controls.
        if (!es) pc = ec ? et : pc + 32'd4;
    endtask

    task automatic apply(input vec_t v, input string tag);
        drive(v.rst, v.se, v.te, v.sd, v.g, v.rv, v.rd);
        check_outs(tag, v.e_addr, v.e_req, v.e_stall, v.e_src, v.e_tgt,
                   v.e_valid, v.e_instr, v.e_err);
    endtask

    // Reference model: what the fetch unit is doing, expressed as activity flags.
    bit          m_boot, m_ask, m_wait, m_hold, m_steer, m_dead, m_pend, m_err;
    logic [31:0] m_tgt, m_buf;
    int          m_stuck;

    task automatic model_reset();
        m_boot = 1; m_ask = 0; m_wait = 0; m_hold = 0; m_steer = 0; m_dead = 0;
        m_pend = 0; m_err = 0; m_tgt = 32'h0; m_buf = NOP; m_stuck = 0;
    endtask

    task automatic model_step(input logic r, input logic se, input logic [31:0] te,
                              input logic sd, input logic g, input logic rv,
                              input logic [31:0] rd);
        bit old_pend;
        if (r) begin
            model_reset();
            return;
        end
        old_pend = m_pend;
        if (se && (m_boot || m_ask || m_wait)) begin
            m_pend = 1;
            m_tgt  = te;
        end
        if (m_boot) begin
            m_boot = 0; m_ask = 1; m_stuck = 0;
        end else if (m_ask) begin
            if (g) begin m_ask = 0; m_wait = 1; m_stuck = 0; end
            else m_stuck++;
        end else if (m_wait) begin
            if (rv) begin
                m_wait = 0; m_stuck = 0;
                if (old_pend || se) m_steer = 1;
                else begin m_hold = 1; m_buf = rd; end
            end else m_stuck++;
        end else if (m_hold) begin
            if (se || m_pend || !sd) begin m_hold = 0; m_ask = 1; m_pend = 0; end
        end else if (m_steer) begin
            m_steer = 0; m_ask = 1; m_pend = 0;
        end
        if (m_stuck == TMO) begin
            m_ask = 0; m_wait = 0; m_dead = 1; m_err = 1; m_stuck = 0;
        end
    endtask

    localparam logic [31:0] I1 = 32'h0050_0093;
    localparam logic [31:0] I2 = 32'h00a0_0113;
    localparam logic [31:0] I3 = 32'h1111_1111;
    localparam logic [31:0] I4 = 32'h2222_2222;
    localparam logic [31:0] I5 = 32'h4444_4444;

    initial begin
        rst = 1'b1; PCSrcE = 1'b0; PCTargetE = 32'h0; StallD = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; PCF = pc;
        @(posedge clk);

        //          rst se te        sd g  rv rd            addr      rq st sr tgt       v  instr err
        vt.push_back(mk(1, 0, 32'h0,   0, 0, 0, 32'h0,        32'h0,   0, 1, 0, 32'h0,   0, NOP, 0));
        vt.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0,        32'h0,   0, 1, 0, 32'h0,   0, NOP, 0));
        vt.push_back(mk(0, 0, 32'h0,   0, 1, 0, 32'h0,        32'h0,   1, 1, 0, 32'h0,   0, NOP, 0));
        vt.push_back(mk(0, 0, 32'h0,   0, 0, 1, I1,           32'h0,   0, 1, 0, 32'h0,   0, NOP, 0));
        vt.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0,        32'h0,   0, 0, 0, 32'h0,   1, I1,  0));
        vt.push_back(mk(0, 0, 32'h0,   0, 1, 0, 32'h0,        32'h4,   1, 1, 0, 32'h0,   0, NOP, 0));
        vt.push_back(mk(0, 0, 32'h0,   0, 0, 1, I2,           32'h4,   0, 1, 0, 32'h0,   0, NOP, 0));
        vt.push_back(mk(0, 0, 32'h0,   1, 0, 0, 32'h0,        32'h4,   0, 1, 0, 32'h0,   1, I2,  0));
        vt.push_back(mk(0, 0, 32'h0,   1, 0, 0, 32'h0,        32'h4,   0, 1, 0, 32'h0,   1, I2,  0));
        vt.push_back(mk(0, 0, 32'h0,   1, 0, 0, 32'h0,        32'h4,   0, 1, 0, 32'h0,   1, I2,  0));
        vt.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0,        32'h4,   0, 0, 0, 32'h0,   1, I2,  0));
        vt.push_back(mk(0, 0, 32'h0,   0, 1, 0, 32'h0,        32'h8,   1, 1, 0, 32'h0,   0, NOP, 0));
        vt.push_back(mk(0, 1, 32'h100, 0, 0, 0, 32'h0,        32'h8,   0, 1, 0, 32'h0,   0, NOP, 0));
        vt.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0,        32'h8,   0, 1, 0, 32'h0,   0, NOP, 0));
        vt.push_back(mk(0, 0, 32'h0,   0, 0, 1, 32'hdeadbeef, 32'h8,   0, 1, 0, 32'h0,   0, NOP, 0));
        vt.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0,        32'h8,   0, 0, 1, 32'h100, 0, NOP, 0));
        vt.push_back(mk(0, 1, 32'h200, 0, 0, 0, 32'h0,        32'h100, 1, 1, 0, 32'h0,   0, NOP, 0));
        vt.push_back(mk(0, 0, 32'h0,   0, 1, 0, 32'h0,        32'h100, 1, 1, 0, 32'h0,   0, NOP, 0));
        vt.push_back(mk(0, 1, 32'h300, 0, 0, 0, 32'h0,        32'h100, 0, 1, 0, 32'h0,   0, NOP, 0));
        vt.push_back(mk(0, 0, 32'h0,   0, 0, 1, 32'hcafef00d, 32'h100, 0, 1, 0, 32'h0,   0, NOP, 0));
        vt.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0,        32'h100, 0, 0, 1, 32'h300, 0, NOP, 0));
        vt.push_back(mk(0, 0, 32'h0,   0, 1, 0, 32'h0,        32'h300, 1, 1, 0, 32'h0,   0, NOP, 0));
        vt.push_back(mk(0, 0, 32'h0,   0, 0, 1, I3,           32'h300, 0, 1, 0, 32'h0,   0, NOP, 0));
        vt.push_back(mk(0, 0, 32'h0,   1, 0, 0, 32'h0,        32'h300, 0, 1, 0, 32'h0,   1, I3,  0));
        vt.push_back(mk(0, 1, 32'h40,  1, 0, 0, 32'h0,        32'h300, 0, 0, 1, 32'h40,  0, NOP, 0));
        vt.push_back(mk(0, 0, 32'h0,   0, 1, 1, 32'hbadbad00, 32'h40,  1, 1, 0, 32'h0,   0, NOP, 0));
        vt.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0,        32'h40,  0, 1, 0, 32'h0,   0, NOP, 0));
        vt.push_back(mk(0, 0, 32'h0,   0, 0, 1, I4,           32'h40,  0, 1, 0, 32'h0,   0, NOP, 0));
        vt.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0,        32'h40,  0, 0, 0, 32'h0,   1, I4,  0));
        vt.push_back(mk(1, 0, 32'h0,   0, 1, 0, 32'h0,        32'h44,  0, 1, 0, 32'h0,   0, NOP, 0));
        vt.push_back(mk(0, 0, 32'h0,   0, 0, 1, 32'h33333333, 32'h44,  0, 1, 0, 32'h0,   0, NOP, 0));

        for (int i = 0; i < vt.size(); i++) apply(vt[i], $sformatf("row%0d", i));

        // Grant withheld from REQ entry: error exactly TMO cycles later.
        for (int k = 0; k < TMO; k++) begin
            drive(0, 0, 32'h0, 0, 0, 0, 32'h0);
            check_outs($sformatf("tmo%0d", k), 32'h44, 1, 1, 0, 32'h0, 0, NOP, 0);
        end
        for (int k = 0; k < 4; k++) begin
            drive(0, (k == 1), 32'h80, 0, (k != 0), (k != 0), 32'h55555555);
            check_outs($sformatf("halt%0d", k), 32'h44, 0, 1, 0, 32'h0, 0, NOP, 1);
        end
        drive(1, 0, 32'h0, 0, 0, 1, 32'h66666666);
        check_outs("halt_rst", 32'h44, 0, 1, 0, 32'h0, 0, NOP, 1);
        drive(0, 0, 32'h0, 0, 0, 1, 32'h77777777);
        check_outs("stale_idle", 32'h44, 0, 1, 0, 32'h0, 0, NOP, 0);
        drive(0, 0, 32'h0, 0, 1, 0, 32'h0);
        check_outs("rec_req", 32'h44, 1, 1, 0, 32'h0, 0, NOP, 0);
        drive(0, 0, 32'h0, 0, 0, 1, I5);
        check_outs("rec_wait", 32'h44, 0, 1, 0, 32'h0, 0, NOP, 0);
        drive(0, 0, 32'h0, 0, 0, 0, 32'h0);
        check_outs("rec_hold", 32'h44, 0, 0, 0, 32'h0, 1, I5, 0);

        // Randomized traffic against the reference model.
        begin
            int gnt_pct = 80;
            int rv_pct  = 60;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                logic        r, se, sd, g, rv;
                logic [31:0] te, rd, et;
                logic        eq, es, ec, ev;
                logic [31:0] ei;
                if (cyc % 100 == 0) begin
                    case ($urandom_range(0, 2))
                        0:       gnt_pct = 85;
                        1:       gnt_pct = 50;
                        default: gnt_pct = 4;
                    endcase
                    rv_pct = (gnt_pct == 4) ? 30 : 60;
                end
                r  = (cyc == 0) || ($urandom_range(0, 79) == 0);
                se = ($urandom_range(0, 99) < 12);
                te = $urandom() & 32'hFFFF_FFFC;
                sd = ($urandom_range(0, 99) < 35);
                g  = ($urandom_range(0, 99) < gnt_pct);
                rv = ($urandom_range(0, 99) < rv_pct);
                rd = $urandom();

                eq = 0; es = 1; ec = 0; et = 32'h0; ev = 0;
                if (!r) begin
                    eq = m_ask;
                    ev = m_hold && !se && !m_pend;
                    if (m_steer) begin
                        es = 0; ec = 1; et = se ? te : m_tgt;
                    end else if (m_hold && (se || m_pend || !sd)) begin
                        es = 0; ec = se || m_pend; et = se ? te : m_tgt;
                    end
                end
                ei = ev ? m_buf : NOP;

                drive(r, se, te, sd, g, rv, rd);
                check_outs($sformatf("rnd%0d", cyc), pc, eq, es, ec, et, ev, ei, m_err);
                model_step(r, se, te, sd, g, rv, rd);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Fetch-stage controller. Sequences the PC register against a variable-latency instruction memory with a req/gnt/rvalid handshake.
- Drives StallF and the PC next-value select (PCSrcF/PCTargetF) into the PC register.
- Buffers redirects from execute that arrive while a fetch is outstanding.
- Delivers InstrF/InstrValidF to the IF/ID register. One outstanding request at a time.

Parameters:
- NOP_INSTR, 32'h00000013, value driven on InstrF when InstrValidF=0.
- TIMEOUT_CYCLES, 16, cycles in REQ or WAIT before fetch_err is raised (≥2).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- PCF  in  32  current PC from PC register
- PCSrcE  in  1  execute-stage redirect
- PCTargetE  in  32  redirect target
- StallD  in  1  decode cannot accept an instruction this cycle
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (=PCF)
- imem_gnt  in  1  request accepted
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  instruction word
- StallF  out  1  hold PC register
- PCSrcF  out  1  PC register select: 1 = take PCTargetF, 0 = PC+4
- PCTargetF  out  32  redirect target to PC register
- InstrF  out  32  fetched instruction
- InstrValidF  out  1  InstrF valid
- fetch_err  out  1  sticky timeout error

Behaviour:
- Reset values: state IDLE, redir_pend=0, redir_tgt=0, instr_buf=NOP_INSTR, timeout counter=0, fetch_err=0.
- Output values during reset: imem_req=0, StallF=1, PCSrcF=0, InstrValidF=0.
- States: IDLE, REQ, WAIT, HOLD, REDIR, HALT.
- IDLE: one cycle, then REQ.
- REQ: imem_req=1, imem_addr=PCF.
  - Address and request held until imem_gnt; the address never changes while req=1 and gnt=0.
  - On gnt: WAIT.
- WAIT: imem_req=0. On imem_rvalid:
  - if redir_pend=1 or PCSrcE=1: discard data, go to REDIR;
  - else capture imem_rdata into instr_buf, go to HOLD.
- HOLD: InstrF=instr_buf, InstrValidF=1.
  - If PCSrcE=1: StallF=0, PCSrcF=1, PCTargetF=PCTargetE, InstrValidF=0, buffer dropped, go to REQ. This holds regardless of StallD.
  - Else if redir_pend=1: same as above with PCTargetF=redir_tgt; redir_pend cleared.
  - Else if StallD=0: StallF=0, PCSrcF=0; instruction consumed at this edge; go to REQ.
  - Else: stay in HOLD, StallF=1, instr_buf stable.
- REDIR: one cycle, then REQ.
  - StallF=0, PCSrcF=1, PCTargetF = PCSrcE ? PCTargetE : redir_tgt.
  - redir_pend cleared.
- StallF=1, PCSrcF=0 in every case not listed above.
- Redirect capture: PCSrcE=1 in IDLE, REQ or WAIT latches PCTargetE into redir_tgt and sets redir_pend=1.
  - A newer PCSrcE overwrites a pending target.
  - In REQ, a pending redirect does not cancel the issued request; the response is discarded in WAIT.
- InstrValidF=0 whenever state≠HOLD, PCSrcE=1, or redir_pend=1. InstrF=NOP_INSTR whenever InstrValidF=0.
- Timeout counter:
  - Increments each cycle in REQ without gnt and each cycle in WAIT without rvalid.
  - Clears on any state change.
  - When it reaches TIMEOUT_CYCLES: fetch_err=1 (sticky until rst), imem_req=0, state HALT.
- HALT: StallF=1, InstrValidF=0, no requests; exit only by rst.
- imem_rvalid outside WAIT is ignored. This covers stale responses after a mid-transaction reset.
- Reset mid-operation returns to IDLE next cycle, drops instr_buf and redir_pend, and deasserts imem_req immediately.
- Latency: with gnt in REQ and rvalid on the next cycle, an instruction is valid 2 cycles after REQ entry. Sustained throughput is 1 instruction per 3 cycles.

Test Plan:
- Reset release, PCF=0; gnt on first REQ cycle; rvalid next cycle with rdata=32'h00500093; StallD=0 -> InstrValidF=1 for one cycle with InstrF=32'h00500093; StallF=0 that cycle; PCF becomes 4; next imem_addr=4.
- Instruction in HOLD with StallD=1 for 3 cycles -> InstrF stable, StallF=1, imem_req=0 throughout; StallD=0 on the 4th cycle -> PC advances and REQ is entered.
- PCSrcE=1 with PCTargetE=32'h100 during WAIT, rvalid 2 cycles later -> data discarded, InstrValidF stays 0; REDIR cycle shows PCSrcF=1, PCTargetF=32'h100, StallF=0; next imem_addr=32'h100.
- Two redirects, to 32'h200 in REQ and then 32'h300 in WAIT -> only 32'h300 is applied in REDIR.
- PCSrcE=1 with target 32'h40 while in HOLD with StallD=1 -> same cycle StallF=0, PCSrcF=1, InstrValidF=0; next imem_addr=32'h40.
- imem_gnt held 0 -> fetch_err=1 exactly TIMEOUT_CYCLES=16 cycles after REQ entry; imem_req=0 afterwards. rst clears fetch_err, and a stale rvalid after rst is ignored.
